// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam logic [1:0] DISP_BLANK = 2'b00;
  localparam logic [1:0] DISP_SCORE = 2'b01;
  localparam logic [1:0] DISP_BEST  = 2'b10;
  localparam logic [1:0] DISP_FAULT = 2'b11;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_lfsr16.sv
// Free-running 16-bit Galois LFSR; exposes its low OUT_W bits as the random value.
module reaction_lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] rand_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_step(lfsr_q);
  end

  assign rand_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round controller: FSM, random red delay, ms score and best-score tracking.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int          SCORE_W   = 13,
  parameter int          TICK_DIV  = 50000,
  parameter int          MIN_DLY   = 1000,
  parameter int          RAND_W    = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               buttonStart,
  input  logic               buttonHit,
  input  logic               buttonReset,
  output logic               ledRed,
  output logic               ledGreen,
  output logic [SCORE_W-1:0] scoreValue,
  output logic [SCORE_W-1:0] bestValue,
  output logic [1:0]         displaySel,
  output logic               roundDone,
  output logic               falseStart
);

  localparam int PS_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = $clog2(MIN_DLY + 2**RAND_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             state_q, state_d;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               rd_q, rd_d, fs_q, fs_d;
  logic               red_q, red_d, green_q, green_d;
  logic [1:0]         disp_q, disp_d;
  logic [RAND_W-1:0]  rand_val;
  logic               tick;
  logic [DLY_W-1:0]   new_dly;

  reaction_lfsr16 #(.SEED(LFSR_SEED), .OUT_W(RAND_W)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .rand_o (rand_val)
  );

  assign tick    = (ps_q == PS_W'(TICK_DIV - 1));
  assign new_dly = DLY_W'(MIN_DLY) + DLY_W'(rand_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ps_q    <= '0;
      dly_q   <= '0;
      score_q <= '0;
      best_q  <= '1;
      rd_q    <= 1'b0;
      fs_q    <= 1'b0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      disp_q  <= DISP_BLANK;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      dly_q   <= dly_d;
      score_q <= score_d;
      best_q  <= best_d;
      rd_q    <= rd_d;
      fs_q    <= fs_d;
      red_q   <= red_d;
      green_q <= green_d;
      disp_q  <= disp_d;
    end
  end

  // Button priority: reset over hit over start; a hit also masks a start.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    score_d = score_q;
    best_d  = best_q;
    rd_d    = 1'b0;
    fs_d    = 1'b0;
    if (buttonReset) begin
      state_d = IDLE;
      score_d = '0;
      if (state_q == IDLE) best_d = '1;
    end else begin
      case (state_q)
        IDLE, DONE, FAULT: begin
          if (buttonStart && !buttonHit) begin
            state_d = ARMED;
            dly_d   = new_dly;
            score_d = '0;
          end
        end
        ARMED: begin
          if (buttonHit) begin
            state_d = FAULT;
            fs_d    = 1'b1;
          end else if (tick) begin
            dly_d = dly_q - DLY_W'(1);
            if (dly_q == DLY_W'(1)) state_d = GO;
          end
        end
        GO: begin
          if (buttonHit) begin
            state_d = DONE;
            rd_d    = 1'b1;
            if (score_q < best_q) best_d = score_q;
          end else if (tick) begin
            score_d = score_q + SCORE_W'(1);
            if (score_d == SCORE_MAX) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler restarts on every state entry so each phase starts on a whole ms.
  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (state_d != state_q || tick) ps_d = '0;
  end

  // Moore outputs decoded from the next state and registered with it.
  always_comb begin
    red_d   = (state_d == ARMED);
    green_d = (state_d == GO);
    case (state_d)
      IDLE:       disp_d = DISP_BEST;
      GO, DONE:   disp_d = DISP_SCORE;
      FAULT:      disp_d = DISP_FAULT;
      default:    disp_d = DISP_BLANK;
    endcase
  end

  assign ledRed     = red_q;
  assign ledGreen   = green_q;
  assign scoreValue = score_q;
  assign bestValue  = best_q;
  assign displaySel = disp_q;
  assign roundDone  = rd_q;
  assign falseStart = fs_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomised round-level bench for reaction_round_ctrl with a game-rule reference model.
module tb_reaction_round_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MIN_DLY  = 2;
  localparam int RAND_W   = 2;
  localparam int SCORE_W  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_start = 1'b0, b_hit = 1'b0, b_reset = 1'b0;
  logic ledRed, ledGreen, roundDone, falseStart;
  logic [SCORE_W-1:0] scoreValue, bestValue;
  logic [1:0] displaySel;

  int n_checks = 0;
  int n_fail   = 0;
  int m_best   = 15;
  int rd_pulses = 0;
  int fs_pulses = 0;
  logic [15:0] m_rand;

  always #5 clk = ~clk;

  reaction_round_ctrl #(
    .SCORE_W(SCORE_W), .TICK_DIV(TICK_DIV), .MIN_DLY(MIN_DLY),
    .RAND_W(RAND_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .buttonStart(b_start), .buttonHit(b_hit), .buttonReset(b_reset),
    .ledRed(ledRed), .ledGreen(ledGreen),
    .scoreValue(scoreValue), .bestValue(bestValue),
    .displaySel(displaySel), .roundDone(roundDone), .falseStart(falseStart)
  );

  // Reference random source: polynomial x^16+x^14+x^13+x^11+1 stepped once per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rand <= SEED;
    else        m_rand <= (m_rand >> 1) ^ (m_rand[0] ? 16'hB400 : 16'h0000);
  end

  always @(negedge clk) begin
    if (roundDone)  rd_pulses++;
    if (falseStart) fs_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start(output int d_exp);
    d_exp = MIN_DLY + int'(m_rand[RAND_W-1:0]);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("armed_led", ledRed, 1);
    chk("armed_disp", displaySel, 0);
    chk("armed_score", scoreValue, 0);
  endtask

  task automatic wait_go(input int d_exp);
    int cnt = 1;
    while (!ledGreen && cnt < 200) begin
      step();
      cnt++;
    end
    chk("go_reached", ledGreen, 1);
    chk("red_cycles", cnt, d_exp * TICK_DIV + 1);
    chk("red_range", ((cnt - 1) / TICK_DIV >= 2) && ((cnt - 1) / TICK_DIV <= 5), 1);
    chk("go_disp", displaySel, 1);
    chk("go_score0", scoreValue, 0);
  endtask

  task automatic hit_after(input int k, input int r);
    int rd0 = rd_pulses;
    repeat (k * TICK_DIV + r) step();
    b_hit = 1'b1;
    step();
    b_hit = 1'b0;
    if (k < m_best) m_best = k;
    chk("hit_done", roundDone, 1);
    chk("hit_score", scoreValue, k);
    chk("hit_best", bestValue, m_best);
    chk("hit_disp", displaySel, 1);
    chk("hit_green", ledGreen, 0);
    step();
    chk("hit_pulse1", rd_pulses - rd0, 1);
    $display("round hit k=%0d r=%0d score=%0d best=%0d", k, r, scoreValue, bestValue);
  endtask

  task automatic false_hit(input int r);
    int rd0 = rd_pulses;
    int fs0 = fs_pulses;
    repeat (r) step();
    b_hit = 1'b1;
    step();
    b_hit = 1'b0;
    chk("fs_pulse", falseStart, 1);
    chk("fs_disp", displaySel, 3);
    chk("fs_red", ledRed, 0);
    chk("fs_best", bestValue, m_best);
    step();
    chk("fs_width", fs_pulses - fs0, 1);
    chk("fs_no_done", rd_pulses - rd0, 0);
    $display("round false start r=%0d disp=%0d", r, displaySel);
  endtask

  task automatic timeout_round();
    int rd0 = rd_pulses;
    repeat (15 * TICK_DIV + 3) step();
    chk("to_score", scoreValue, 15);
    chk("to_green", ledGreen, 0);
    chk("to_disp", displaySel, 1);
    chk("to_best", bestValue, m_best);
    chk("to_no_done", rd_pulses - rd0, 0);
    $display("round timeout score=%0d best=%0d", scoreValue, bestValue);
  endtask

  task automatic soft_reset(input bit was_idle);
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    if (was_idle) m_best = 15;
    chk("rst_disp", displaySel, 2);
    chk("rst_score", scoreValue, 0);
    chk("rst_best", bestValue, m_best);
    $display("soft reset idle=%0d best=%0d", was_idle, bestValue);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_red"}, ledRed, 0);
    chk({tag, "_green"}, ledGreen, 0);
    chk({tag, "_score"}, scoreValue, 0);
    chk({tag, "_best"}, bestValue, 15);
    chk({tag, "_disp"}, displaySel, 0);
    chk({tag, "_pulses"}, {roundDone, falseStart}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, rd0, mode;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("idle_disp", displaySel, 2);
    $display("reset released disp=%0d best=%0d", displaySel, bestValue);

    press_start(d); wait_go(d); hit_after(3, 1);
    press_start(d); false_hit(2);
    press_start(d); false_hit(4 * d - 1);
    press_start(d); wait_go(d); timeout_round();

    soft_reset(1'b0);
    soft_reset(1'b1);
    press_start(d); wait_go(d); hit_after(5, 0);
    press_start(d); wait_go(d); hit_after(7, 3);
    chk("best_min", bestValue, 5);
    soft_reset(1'b0);
    soft_reset(1'b1);

    press_start(d); wait_go(d); hit_after(0, 0);

    press_start(d); wait_go(d);
    rd0 = rd_pulses;
    repeat (2 * TICK_DIV) step();
    b_hit = 1'b1; b_reset = 1'b1;
    step();
    b_hit = 1'b0; b_reset = 1'b0;
    step();
    chk("hr_disp", displaySel, 2);
    chk("hr_score", scoreValue, 0);
    chk("hr_green", ledGreen, 0);
    chk("hr_no_done", rd_pulses - rd0, 0);
    chk("hr_best", bestValue, m_best);
    $display("hit+reset in GO disp=%0d score=%0d", displaySel, scoreValue);

    press_start(d); wait_go(d);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    m_best = 15;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post_rst_disp", displaySel, 2);
    chk("post_rst_best", bestValue, 15);
    $display("async reset mid-GO best=%0d disp=%0d", bestValue, displaySel);

    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 7)) step();
      mode = $urandom_range(0, 9);
      press_start(d);
      if (mode == 0) begin
        false_hit($urandom_range(0, 4 * d - 1));
      end else begin
        wait_go(d);
        if (mode == 1) timeout_round();
        else hit_after($urandom_range(0, 14), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
